time_counter: RTL
=================

# time_counter

Free-running 24-hour time-of-day counter that produces binary hours/minutes/seconds for the downstream time decoder, which converts them to 12-hour display form and drives the PM LED. A parameterised prescaler derives a 1 Hz tick from the system clock. The counter supports synchronous time load, single-step hour/minute adjust from debounced buttons, and a run/pause control. All outputs are registered.

## Interface
- CLK_HZ, default 100_000_000: system clock cycles per second tick; must be ≥ 2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = prescaler and time advance; 0 = hold all state.
- load  in  1  single-cycle strobe; loads set_hours/set_minutes/set_seconds.
- set_hours  in  8  binary hours for load, legal 0–23.
- set_minutes  in  8  binary minutes for load, legal 0–59.
- set_seconds  in  8  binary seconds for load, legal 0–59.
- inc_hour  in  1  single-cycle strobe (debounced upstream); hours +1 mod 24.
- inc_min  in  1  single-cycle strobe; minutes +1 mod 60.
- hours_in  out  8  binary hours 0–23 (feeds the decoder's hours_in).
- minutes_in  out  8  binary minutes 0–59.
- seconds_in  out  8  binary seconds 0–59.
- sec_tick  out  1  one-cycle pulse, high in the cycle after seconds advanced by a tick.
- day_wrap  out  1  one-cycle pulse, high when 23:59:59 → 00:00:00 occurred.
- load_err  out  1  one-cycle pulse, high when a load was rejected.

## Operation
- Prescaler: counter width $clog2(CLK_HZ), counts 0..CLK_HZ-1 while run=1; at CLK_HZ-1 it wraps to 0 and issues an internal tick.
- Tick: seconds +1; 59 → 0 carries to minutes; minutes 59 → 0 carries to hours; hours 23 → 0 on a full carry, which also asserts day_wrap.
- Priority per cycle: load > inc_hour/inc_min > tick.
- load with all fields legal: the three outputs take set_* values and the prescaler clears to 0. If any field is out of range, no state changes and load_err pulses. load acts regardless of run.
- inc_hour/inc_min: the field wraps modulo its range with no carry into other fields; seconds are untouched. Both strobes in the same cycle apply both increments. They act regardless of run.
- In any cycle with load or inc asserted, the prescaler does not advance (load clears it). A pending tick is therefore delayed one cycle, never lost or merged.
- run=0: prescaler and time hold; sec_tick and day_wrap stay 0.
- Reset values: prescaler 0; hours_in, minutes_in and seconds_in 0; sec_tick, day_wrap and load_err 0.

## Timing
- All outputs are registered. A load or inc at edge k is visible on the outputs after edge k (latency 1).
- Tick period is exactly CLK_HZ cycles of run=1 with no load/inc. The first tick after reset or load occurs CLK_HZ run-cycles later.
- sec_tick and day_wrap are asserted for exactly the one cycle following the edge that updated the time. day_wrap implies sec_tick.
- rst_n low mid-count forces reset values immediately, independent of clk. Counting resumes on the first edge after rst_n goes high.

## Test plan
- Reset then run=1 with CLK_HZ=4: seconds_in is 1 after 4 cycles. sec_tick fires every 4th cycle, each time for 1 cycle.
- Load 23:59:58, run 8 cycles (CLK_HZ=4): the outputs pass through 23:59:59 and then 00:00:00; day_wrap pulses once, together with sec_tick.
- Load hours=24, minutes=10, seconds=0: load_err pulses and the time is unchanged. Load 12:60:00: load_err pulses.
- At 23:59:xx, pulse inc_hour and inc_min together: the result is 00:00:xx with no day_wrap. A strobe on the cycle where the prescaler sits at 3 delays the tick by exactly 1 cycle.
- Toggle run=0 for 10 cycles mid-count: outputs and tick phase are frozen, and counting resumes from the same prescaler value.
- Assert rst_n low between clock edges at 13:45:30: outputs go to 0 immediately, and all pulse outputs are 0.

Source files
------------

// File: rtl/time_counter.sv
// time_counter -- free-running 24-hour time-of-day counter.
//
// A prescaler divides the system clock down to a 1 Hz tick that advances a
// binary hh:mm:ss counter. The time can be loaded synchronously, hours and
// minutes can be single-stepped from debounced buttons, and run=0 freezes
// both the prescaler and the time. All outputs are registered.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   run          1 = prescaler and time advance, 0 = hold
//   load         single-cycle strobe, loads set_hours/set_minutes/set_seconds
//   set_hours    load value for hours   (legal 0..23)
//   set_minutes  load value for minutes (legal 0..59)
//   set_seconds  load value for seconds (legal 0..59)
//   inc_hour     single-cycle strobe, hours +1 mod 24 (no carry)
//   inc_min      single-cycle strobe, minutes +1 mod 60 (no carry)
//   hours_in     binary hours 0..23
//   minutes_in   binary minutes 0..59
//   seconds_in   binary seconds 0..59
//   sec_tick     one-cycle pulse after seconds advanced by a tick
//   day_wrap     one-cycle pulse after 23:59:59 -> 00:00:00
//   load_err     one-cycle pulse after a load was rejected
module time_counter #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_minutes,
  input  logic [7:0] set_seconds,
  input  logic       inc_hour,
  input  logic       inc_min,
  output logic [7:0] hours_in,
  output logic [7:0] minutes_in,
  output logic [7:0] seconds_in,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hours_q, hours_d;
  logic [7:0]    minutes_q, minutes_d;
  logic [7:0]    seconds_q, seconds_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_wrap_q, day_wrap_d;
  logic          load_err_q, load_err_d;

  logic load_ok;
  logic tick;

  assign load_ok = (set_hours < 8'd24) && (set_minutes < 8'd60) &&
                   (set_seconds < 8'd60);

  // The prescaler only counts in cycles with no load/inc, so a strobe that
  // lands on the wrap cycle pushes the tick out by one cycle instead of
  // losing it.
  assign tick = run && !load && !inc_hour && !inc_min && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d    = presc_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    load_err_d = 1'b0;

    if (load) begin
      if (load_ok) begin
        hours_d   = set_hours;
        minutes_d = set_minutes;
        seconds_d = set_seconds;
        presc_d   = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (inc_hour || inc_min) begin
      if (inc_hour) hours_d   = (hours_q   == 8'd23) ? 8'd0 : hours_q + 8'd1;
      if (inc_min)  minutes_d = (minutes_q == 8'd59) ? 8'd0 : minutes_q + 8'd1;
    end else if (run) begin
      if (tick) begin
        presc_d    = '0;
        sec_tick_d = 1'b1;
        if (seconds_q == 8'd59) begin
          seconds_d = 8'd0;
          if (minutes_q == 8'd59) begin
            minutes_d = 8'd0;
            if (hours_q == 8'd23) begin
              hours_d    = 8'd0;
              day_wrap_d = 1'b1;
            end else begin
              hours_d = hours_q + 8'd1;
            end
          end else begin
            minutes_d = minutes_q + 8'd1;
          end
        end else begin
          seconds_d = seconds_q + 8'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      hours_q    <= '0;
      minutes_q  <= '0;
      seconds_q  <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign hours_in   = hours_q;
  assign minutes_in = minutes_q;
  assign seconds_in = seconds_q;
  assign sec_tick   = sec_tick_q;
  assign day_wrap   = day_wrap_q;
  assign load_err   = load_err_q;

endmodule
